// File: rtl/fractal_colorizer.sv
// Maps fractal iteration counts to RGB through a writable 256-entry palette,
// buffering the resulting AXI-Stream beats in an output FIFO (input has no backpressure).
module fractal_colorizer #(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_ITER   = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  s_data,
    input  logic        s_user,
    input  logic        s_last,
    input  logic        s_valid,
    input  logic        pal_we,
    input  logic [7:0]  pal_addr,
    input  logic [23:0] pal_wdata,
    output logic [23:0] m_tdata,
    output logic        m_tuser,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        overflow,
    output logic [15:0] frame_count
);

    localparam int              AW     = $clog2(FIFO_DEPTH);
    localparam int              CW     = AW + 1;
    localparam logic [CW-1:0]   FULL   = CW'(FIFO_DEPTH);
    localparam logic [7:0]      INSIDE = 8'(MAX_ITER);

    // Palette: not reset, read-before-write on a same-address collision.
    logic [23:0] pal_mem [256];
    logic [23:0] pal_q;

    always_ff @(posedge clk) begin
        if (resetn && pal_we) begin
            pal_mem[pal_addr] <= pal_wdata;
        end
        pal_q <= pal_mem[s_data];
    end

    // Stage 1: capture the input beat alongside the palette lookup.
    logic       v1;
    logic       u1;
    logic       l1;
    logic [7:0] d1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            v1 <= 1'b0;
        end else begin
            v1 <= s_valid;
        end
        u1 <= s_user;
        l1 <= s_last;
        d1 <= s_data;
    end

    // Stage 2: points inside the set are forced to black.
    logic        v2;
    logic        u2;
    logic        l2;
    logic [23:0] rgb2;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            v2 <= 1'b0;
        end else begin
            v2 <= v1;
        end
        u2   <= u1;
        l2   <= l1;
        rgb2 <= (d1 == INSIDE) ? '0 : pal_q;
    end

    // Output FIFO entries are {user, last, rgb}.
    logic [25:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [25:0]   head;
    logic          rd;
    logic          wr_ok;
    logic          wr_drop;

    always_comb begin
        head     = fifo_mem[rd_ptr];
        m_tvalid = (count != '0);
        rd       = m_tvalid && m_tready;
        // A full FIFO still takes a write when the head leaves in the same cycle.
        wr_ok    = v2 && ((count < FULL) || rd);
        wr_drop  = v2 && !wr_ok;
        m_tdata  = head[23:0];
        m_tuser  = m_tvalid && head[25];
        m_tlast  = m_tvalid && head[24];
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            fifo_mem[wr_ptr] <= {u2, l2, rgb2};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            overflow    <= 1'b0;
            frame_count <= '0;
        end else begin
            if (wr_drop) begin
                overflow <= 1'b1;
            end
            if (rd && m_tuser) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fractal_colorizer.sv
// Self-checking bench for fractal_colorizer: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_fractal_colorizer;

    localparam int DEPTH    = 16;
    localparam int MAX_ITER = 255;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  s_data;
    logic        s_user;
    logic        s_last;
    logic        s_valid;
    logic        pal_we;
    logic [7:0]  pal_addr;
    logic [23:0] pal_wdata;
    logic [23:0] m_tdata;
    logic        m_tuser;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic        overflow;
    logic [15:0] frame_count;

    fractal_colorizer #(.FIFO_DEPTH(DEPTH), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .resetn(resetn),
        .s_data(s_data), .s_user(s_user), .s_last(s_last), .s_valid(s_valid),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
        .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .overflow(overflow), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Reference model: beats in flight carry the edge at which they reach the FIFO.
    typedef struct {
        int          due;
        logic [25:0] word;
    } flight_t;

    typedef struct {
        logic [7:0]  data;
        logic        user;
        logic        last;
        logic        wr;
        logic [23:0] pal;
        logic [23:0] exp_rgb;
    } vec_t;

    flight_t     inflight[$];
    logic [25:0] mq[$];
    logic [23:0] pal_m [256];
    logic        ovf_m = 1'b0;
    logic [15:0] fc_m = '0;
    int          edge_no = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [23:0] fill_val(input int a);
        logic [7:0] b;
        b = 8'(a);
        return {b, ~b, b ^ 8'h5A};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic v, input logic [7:0] d, input logic u, input logic l);
        s_valid = v;
        s_data  = d;
        s_user  = u;
        s_last  = l;
    endtask

    task automatic set_pal(input logic we, input logic [7:0] a, input logic [23:0] w);
        pal_we    = we;
        pal_addr  = a;
        pal_wdata = w;
    endtask

    // One clock edge: advance the model with the driven inputs, then compare.
    task automatic tick();
        int          sz;
        logic        rd;
        flight_t     f;
        logic [23:0] col;
        @(posedge clk);
        if (!resetn) begin
            mq.delete();
            inflight.delete();
            ovf_m = 1'b0;
            fc_m  = '0;
        end else begin
            sz = mq.size();
            rd = (sz != 0) && m_tready;
            if (rd) begin
                if (mq[0][25]) fc_m = fc_m + 16'd1;
                void'(mq.pop_front());
            end
            while (inflight.size() != 0 && inflight[0].due == edge_no) begin
                f = inflight.pop_front();
                if (sz < DEPTH || rd) mq.push_back(f.word);
                else ovf_m = 1'b1;
            end
            if (s_valid) begin
                col    = (int'(s_data) == MAX_ITER) ? 24'h000000 : pal_m[s_data];
                f.due  = edge_no + 2;
                f.word = {s_user, s_last, col};
                inflight.push_back(f);
            end
            if (pal_we) pal_m[pal_addr] = pal_wdata;
        end
        edge_no++;
        #2;
        chk("model_tvalid", m_tvalid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("model_tdata", m_tdata, mq[0][23:0]);
            chk("model_tuser", m_tuser, mq[0][25]);
            chk("model_tlast", m_tlast, mq[0][24]);
        end
        chk("model_overflow", overflow, ovf_m);
        chk("model_frame_count", frame_count, fc_m);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vt[6];
        logic [15:0] fc_before;
        int          drained;

        vt[0] = '{data: 8'd5,   user: 1'b1, last: 1'b0, wr: 1'b1, pal: 24'h123456, exp_rgb: 24'h123456};
        vt[1] = '{data: 8'd255, user: 1'b0, last: 1'b1, wr: 1'b1, pal: 24'hFFFFFF, exp_rgb: 24'h000000};
        vt[2] = '{data: 8'd200, user: 1'b0, last: 1'b0, wr: 1'b0, pal: 24'h000000, exp_rgb: 24'hC83792};
        vt[3] = '{data: 8'd0,   user: 1'b0, last: 1'b1, wr: 1'b0, pal: 24'h000000, exp_rgb: 24'h00FF5A};
        vt[4] = '{data: 8'd254, user: 1'b1, last: 1'b1, wr: 1'b1, pal: 24'hABCDEF, exp_rgb: 24'hABCDEF};
        vt[5] = '{data: 8'd128, user: 1'b0, last: 1'b0, wr: 1'b0, pal: 24'h000000, exp_rgb: 24'h807FDA};

        // Reset with live-looking traffic that must be ignored.
        resetn   = 1'b0;
        m_tready = 1'b1;
        set_in(1'b1, 8'd77, 1'b1, 1'b1);
        set_pal(1'b1, 8'd77, 24'hBAD000);
        repeat (3) tick();
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tuser", m_tuser, 1'b0);
        chk("rst_tlast", m_tlast, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_frame_count", frame_count, 16'd0);

        resetn = 1'b1;
        set_in(1'b0, 8'd0, 1'b0, 1'b0);
        for (int a = 0; a < 256; a++) begin
            set_pal(1'b1, 8'(a), fill_val(a));
            tick();
        end

        // Palette write and beat during reset must both be ignored.
        resetn = 1'b0;
        set_in(1'b1, 8'd200, 1'b0, 1'b0);
        set_pal(1'b1, 8'd200, 24'hDEADBE);
        tick();
        resetn = 1'b1;
        set_in(1'b0, 8'd0, 1'b0, 1'b0);
        set_pal(1'b0, 8'd0, 24'h0);
        tick();

        for (int i = 0; i < 6; i++) begin
            if (vt[i].wr) begin
                set_pal(1'b1, vt[i].data, vt[i].pal);
                tick();
                set_pal(1'b0, 8'd0, 24'h0);
            end
            fc_before = fc_m;
            set_in(1'b1, vt[i].data, vt[i].user, vt[i].last);
            tick();
            set_in(1'b0, 8'd0, 1'b0, 1'b0);
            tick();
            chk("vec_latency_early", m_tvalid, 1'b0);
            tick();
            chk("vec_tvalid", m_tvalid, 1'b1);
            chk("vec_tdata", m_tdata, vt[i].exp_rgb);
            chk("vec_tuser", m_tuser, vt[i].user);
            chk("vec_tlast", m_tlast, vt[i].last);
            tick();
            chk("vec_frame_count", frame_count, fc_before + 16'(vt[i].user));
            chk("vec_drained", m_tvalid, 1'b0);
        end

        // Same-cycle palette write and lookup of address 9.
        set_pal(1'b1, 8'd9, 24'h999999);
        set_in(1'b1, 8'd9, 1'b0, 1'b0);
        tick();
        set_pal(1'b0, 8'd0, 24'h0);
        tick();
        set_in(1'b0, 8'd0, 1'b0, 1'b0);
        tick();
        chk("rbw_old", m_tdata, fill_val(9));
        tick();
        chk("rbw_new", m_tdata, 24'h999999);
        tick();
        chk("rbw_drained", m_tvalid, 1'b0);

        // 17 beats into a stalled FIFO: the last one is dropped.
        m_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            set_in(1'b1, 8'(16 + i), i == 0, (i % 4) == 3);
            tick();
        end
        set_in(1'b0, 8'd0, 1'b0, 1'b0);
        repeat (3) tick();
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_full_valid", m_tvalid, 1'b1);
        m_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("ovf_drain_data", m_tdata, fill_val(16 + i));
            chk("ovf_drain_user", m_tuser, i == 0);
            chk("ovf_drain_last", m_tlast, (i % 4) == 3);
            tick();
        end
        chk("ovf_17th_absent", m_tvalid, 1'b0);
        chk("ovf_sticky", overflow, 1'b1);

        // One-cycle reset with 8 buffered beats and 2 more in flight.
        m_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 8'(40 + i), 1'b0, 1'b0);
            tick();
        end
        resetn = 1'b0;
        set_pal(1'b1, 8'd40, 24'h000001);
        tick();
        resetn = 1'b1;
        set_in(1'b0, 8'd0, 1'b0, 1'b0);
        set_pal(1'b0, 8'd0, 24'h0);
        chk("pulse_tvalid", m_tvalid, 1'b0);
        chk("pulse_overflow", overflow, 1'b0);
        chk("pulse_frame_count", frame_count, 16'd0);
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("pulse_no_partial", m_tvalid, 1'b0);
        end
        set_in(1'b1, 8'd40, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 8'd0, 1'b0, 1'b0);
        repeat (2) tick();
        chk("pulse_palette_kept", m_tdata, fill_val(40));
        tick();

        // Full FIFO with a read every cycle must keep accepting input.
        for (int j = 0; j < 42; j++) begin
            m_tready = (j >= 18);
            if (j < 40) set_in(1'b1, 8'($urandom_range(0, 254)), 1'b0, 1'b0);
            else set_in(1'b0, 8'd0, 1'b0, 1'b0);
            tick();
            if (j >= 17) chk("full_stream_valid", m_tvalid, 1'b1);
        end
        chk("full_stream_no_overflow", overflow, 1'b0);
        m_tready = 1'b0;
        tick();
        drained  = 0;
        m_tready = 1'b1;
        for (int k = 0; k < 40 && m_tvalid; k++) begin
            drained++;
            tick();
        end
        chk("full_stream_count", drained, 16);

        // Randomized traffic with varying downstream readiness.
        for (int c = 0; c < 3000; c++) begin
            if ((c % 200) == 0) m_tready = 1'b1;
            resetn = ($urandom_range(0, 399) != 0);
            m_tready = ((c / 200) % 3 == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
            set_in($urandom_range(0, 9) < 7,
                   ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom),
                   $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            set_pal($urandom_range(0, 15) == 0, 8'($urandom), 24'($urandom));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
